bus_sequencer: RTL and testbench
================================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL provide parameter NUM_REGS, default 4, giving the number of general registers sequenced (index width IW = clog2(NUM_REGS)).
REQ-002 SHALL provide parameter ALU_HOLD, default 1, range 1..15, giving the number of cycles operands are held on the left/right buses.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: i_clk (in, 1) is the single clock; i_rst_n (in, 1) is the asynchronous active-low reset.
REQ-004 i_cmd_valid  in  1  command offered.
REQ-005 o_cmd_ready  out  1  controller can accept a command.
REQ-006 i_cmd_op  in  2  operation: 0 NOP, 1 MOVE, 2 ALU_READ, 3 LOAD_EXT.
REQ-007 i_src, i_dst, i_left_sel, i_right_sel  in  IW each  register indices.
REQ-008 o_assert_transfer  out  NUM_REGS  one-hot (or zero) transfer-bus drive enables.
REQ-009 o_load_transfer  out  NUM_REGS  one-hot (or zero) load strobes; each register latches on the falling edge.
REQ-010 o_assert_left, o_assert_right  out  NUM_REGS each  one-hot (or zero) ALU operand bus enables.
REQ-011 o_ext_assert  out  1  tells the external device to drive the transfer bus (LOAD_EXT).
REQ-012 o_operands_valid  out  1  left/right buses are stable for the ALU.
REQ-013 o_done  out  1  single-cycle completion pulse.
REQ-014 o_error  out  1  single-cycle pulse when a command is rejected.

Function
REQ-015 All outputs SHALL be registered, and the FSM SHALL have the states IDLE, DRIVE, LATCH, RELEASE and OPERANDS.
REQ-016 A command SHALL be accepted on a rising edge where i_cmd_valid=1 and o_cmd_ready=1; o_cmd_ready SHALL be 1 only in IDLE.
REQ-017 Command fields SHALL be captured at acceptance, and later input changes SHALL be ignored until the next acceptance.
REQ-018 MOVE SHALL sequence IDLE->DRIVE->LATCH->RELEASE->IDLE.
REQ-018a In DRIVE, assert_transfer[src]=1.
REQ-018b In LATCH, assert_transfer[src]=1 and load_transfer[dst]=1.
REQ-018c In RELEASE, assert_transfer[src]=1 and load_transfer=0; this falling edge latches the value while the bus is still driven.
REQ-019 A transfer-bus drive enable SHALL never drop in the same cycle that load_transfer falls.
REQ-020 At most one bit of o_assert_transfer SHALL be set at any time (no bus contention), and o_ext_assert SHALL never coincide with any assert_transfer bit.
REQ-021 LOAD_EXT SHALL follow the same states as MOVE, with o_ext_assert in place of assert_transfer[src]; i_src is ignored.
REQ-022 ALU_READ SHALL sequence IDLE->OPERANDS for exactly ALU_HOLD cycles, then IDLE.
REQ-022a In OPERANDS, assert_left[left_sel]=1, assert_right[right_sel]=1 and o_operands_valid=1.
REQ-023 When left_sel==right_sel, both the left and right enables of that one register SHALL be set.
REQ-024 o_done SHALL pulse in the first IDLE cycle after completion, so that MOVE/LOAD_EXT reach done 4 cycles after acceptance and ALU_READ reaches done ALU_HOLD+1 cycles after acceptance.
REQ-025 A new command SHALL be acceptable in the same cycle that o_done=1.
REQ-026 MOVE with src==dst SHALL produce no strobes, stay in IDLE and pulse o_done on the next cycle.
REQ-027 NOP SHALL likewise produce no strobes and pulse o_done on the next cycle.
REQ-028 Any index >= NUM_REGS SHALL reject the command: no strobes, o_error pulses for 1 cycle on the next cycle, o_done stays 0, and the FSM stays in IDLE.
REQ-029 Outside the stated states, all enables SHALL be 0.

Reset
REQ-030 While i_rst_n=0, all enable outputs, o_operands_valid, o_done and o_error SHALL be 0; the state SHALL be IDLE; and o_cmd_ready SHALL be 0.
REQ-031 o_cmd_ready SHALL rise on the first i_clk rising edge after i_rst_n deasserts.
REQ-032 Reset asserted mid-operation SHALL clear all strobes immediately and SHALL NOT pulse o_done; destination register contents are undefined after an interrupted LATCH.

Verification
REQ-033 MOVE src=1 dst=3 with R1=0xA5 -> assert_transfer=0010 for cycles 1-3, load_transfer=1000 in cycle 2 only, o_done in cycle 4, and R3=0xA5.
REQ-034 ALU_READ left=0 right=2 with ALU_HOLD=3 -> assert_left=0001, assert_right=0100 and operands_valid=1 for cycles 1-3, then o_done in cycle 4.
REQ-035 MOVE src=2 dst=2 -> all enables stay 0 and o_done occurs at cycle 1; dst=5 with NUM_REGS=4 -> o_error at cycle 1 and no strobes.
REQ-036 Back-to-back: LOAD_EXT dst=0 with the bus at 0x3C, then MOVE 0->1 accepted in the o_done cycle -> R0=R1=0x3C, o_ext_assert never overlaps assert_transfer, and at most one assert_transfer bit is ever set.
REQ-037 i_rst_n low during LATCH -> all outputs 0 asynchronously, no o_done, and after release o_cmd_ready=1 on the next rising edge.

Source files
------------

// File: rtl/bus_sequencer.sv
// Purpose: sequences register-to-register transfers, external loads and ALU operand reads over shared buses.
// Latency: MOVE/LOAD_EXT done 4 cycles after acceptance, ALU_READ done ALU_HOLD+1 cycles, NOP/no-op/reject 1 cycle.
// Backpressure: o_cmd_ready is high only in IDLE; a command is taken on an edge where i_cmd_valid and o_cmd_ready are both high.
module bus_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int ALU_HOLD = 1,
    // One bit of headroom beyond the register count so an out-of-range
    // index can actually be presented on the ports and rejected.
    localparam int IW = $clog2(NUM_REGS) + 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [IW-1:0]       i_src,
    input  logic [IW-1:0]       i_dst,
    input  logic [IW-1:0]       i_left_sel,
    input  logic [IW-1:0]       i_right_sel,
    output logic [NUM_REGS-1:0] o_assert_transfer,
    output logic [NUM_REGS-1:0] o_load_transfer,
    output logic [NUM_REGS-1:0] o_assert_left,
    output logic [NUM_REGS-1:0] o_assert_right,
    output logic                o_ext_assert,
    output logic                o_operands_valid,
    output logic                o_done,
    output logic                o_error
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRIVE    = 3'd1;
    localparam logic [2:0] ST_LATCH    = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_OPERANDS = 3'd4;

    localparam logic [1:0] OP_NOP      = 2'd0;
    localparam logic [1:0] OP_MOVE     = 2'd1;
    localparam logic [1:0] OP_ALU_READ = 2'd2;
    localparam logic [1:0] OP_LOAD_EXT = 2'd3;

    localparam logic [3:0] HOLD_INIT = 4'(ALU_HOLD - 1);

    logic [2:0]          state_q, state_d;
    logic [IW-1:0]       src_q, src_d;
    logic [IW-1:0]       dst_q, dst_d;
    logic [IW-1:0]       left_q, left_d;
    logic [IW-1:0]       right_q, right_d;
    logic                ext_q, ext_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                done_d, err_d;

    logic                bus_phase;
    logic                opnd_phase;
    logic [NUM_REGS-1:0] at_d, lt_d, al_d, ar_d;
    logic                ext_assert_d;
    logic                rdy_d;

    function automatic logic idx_ok(input logic [IW-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (int'(idx) == i);
        end
        return v;
    endfunction

    // Next-state logic: capture command fields at acceptance, walk the bus or operand phases.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        left_d  = left_q;
        right_d = right_q;
        ext_d   = ext_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && o_cmd_ready) begin
                    src_d   = i_src;
                    dst_d   = i_dst;
                    left_d  = i_left_sel;
                    right_d = i_right_sel;
                    ext_d   = 1'b0;
                    case (i_cmd_op)
                        OP_NOP: begin
                            done_d = 1'b1;
                        end
                        OP_MOVE: begin
                            if (!idx_ok(i_src) || !idx_ok(i_dst)) begin
                                err_d = 1'b1;
                            end else if (i_src == i_dst) begin
                                // Copying a register onto itself needs no bus activity.
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_DRIVE;
                            end
                        end
                        OP_ALU_READ: begin
                            if (!idx_ok(i_left_sel) || !idx_ok(i_right_sel)) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = ST_OPERANDS;
                                cnt_d   = HOLD_INIT;
                            end
                        end
                        OP_LOAD_EXT: begin
                            // The source index is irrelevant: the external device drives the bus.
                            if (!idx_ok(i_dst)) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = ST_DRIVE;
                                ext_d   = 1'b1;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_DRIVE: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_LATCH + 3'd1;
            end
            ST_RELEASE: begin
                // The load strobe has fallen with the bus still driven; now the bus can be released.
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_OPERANDS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decode the enables for the upcoming state so every output can be a flop.
    always_comb begin
        bus_phase    = (state_d == ST_DRIVE) || (state_d == ST_LATCH) || (state_d == ST_RELEASE);
        opnd_phase   = (state_d == ST_OPERANDS);
        at_d         = (bus_phase && !ext_d) ? onehot(src_d) : '0;
        ext_assert_d = bus_phase && ext_d;
        lt_d         = (state_d == ST_LATCH) ? onehot(dst_d) : '0;
        al_d         = opnd_phase ? onehot(left_d) : '0;
        ar_d         = opnd_phase ? onehot(right_d) : '0;
        rdy_d        = (state_d == ST_IDLE);
    end

    // State and captured command fields.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            ext_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            left_q  <= left_d;
            right_q <= right_d;
            ext_q   <= ext_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs; reset drops every strobe immediately and holds ready low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cmd_ready       <= 1'b0;
            o_assert_transfer <= '0;
            o_load_transfer   <= '0;
            o_assert_left     <= '0;
            o_assert_right    <= '0;
            o_ext_assert      <= 1'b0;
            o_operands_valid  <= 1'b0;
            o_done            <= 1'b0;
            o_error           <= 1'b0;
        end else begin
            o_cmd_ready       <= rdy_d;
            o_assert_transfer <= at_d;
            o_load_transfer   <= lt_d;
            o_assert_left     <= al_d;
            o_assert_right    <= ar_d;
            o_ext_assert      <= ext_assert_d;
            o_operands_valid  <= opnd_phase;
            o_done            <= done_d;
            o_error           <= err_d;
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: per-cycle timeline model plus a register file driven by the DUT strobes.
// Latency: expected outputs are placed on absolute cycle numbers relative to each acceptance.
// Backpressure: commands wait (bounded) for o_cmd_ready before being offered.
module tb_bus_sequencer;
    localparam int NR   = 4;
    localparam int HOLD = 3;
    localparam int IW   = 3;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic [3:0] at;
        logic [3:0] lt;
        logic [3:0] al;
        logic [3:0] ar;
        logic       ext;
        logic       ov;
        logic       done;
        logic       err;
        logic       rdy;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd_op;
    logic [IW-1:0] i_src, i_dst, i_left_sel, i_right_sel;
    logic [NR-1:0] o_assert_transfer, o_load_transfer, o_assert_left, o_assert_right;
    logic          o_ext_assert, o_operands_valid, o_done, o_error;

    bus_sequencer #(.NUM_REGS(NR), .ALU_HOLD(HOLD)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_src(i_src), .i_dst(i_dst), .i_left_sel(i_left_sel), .i_right_sel(i_right_sel),
        .o_assert_transfer(o_assert_transfer), .o_load_transfer(o_load_transfer),
        .o_assert_left(o_assert_left), .o_assert_right(o_assert_right),
        .o_ext_assert(o_ext_assert), .o_operands_valid(o_operands_valid),
        .o_done(o_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    exp_t       exp_q [0:DEPTH-1];
    logic [7:0] regs  [NR];
    logic [7:0] mregs [NR];
    logic [7:0] ext_bus;
    logic [3:0] prev_lt;
    logic       chk_en;
    int         checks;
    int         errors;

    function automatic exp_t cur();
        exp_t e;
        e.at = o_assert_transfer; e.lt = o_load_transfer;
        e.al = o_assert_left;     e.ar = o_assert_right;
        e.ext = o_ext_assert;     e.ov = o_operands_valid;
        e.done = o_done;          e.err = o_error;
        e.rdy = o_cmd_ready;
        return e;
    endfunction

    // Value on the transfer bus: 00 when undriven, EE on contention.
    function automatic logic [7:0] bus_val();
        logic [7:0] v;
        int n;
        v = 8'h00;
        n = 0;
        if (o_ext_assert) begin v = ext_bus; n++; end
        for (int k = 0; k < NR; k++) begin
            if (o_assert_transfer[k]) begin v = regs[k]; n++; end
        end
        if (n > 1) v = 8'hEE;
        return v;
    endfunction

    task automatic reset_exp();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q[i] = '0;
            exp_q[i].rdy = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Timeline model: what each cycle after acceptance cycle c must show.
    task automatic model(input int c, input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                         input logic [2:0] l, input logic [2:0] r);
        logic [3:0] one;
        one = 4'b0001;
        case (op)
            2'd0: exp_q[c+1].done = 1'b1;
            2'd1: begin
                if (s >= NR || d >= NR) exp_q[c+1].err = 1'b1;
                else if (s == d) exp_q[c+1].done = 1'b1;
                else begin
                    for (int k = 1; k <= 3; k++) begin
                        exp_q[c+k].at = one << s;
                        exp_q[c+k].rdy = 1'b0;
                    end
                    exp_q[c+2].lt = one << d;
                    exp_q[c+4].done = 1'b1;
                    mregs[d[1:0]] = mregs[s[1:0]];
                end
            end
            2'd2: begin
                if (l >= NR || r >= NR) exp_q[c+1].err = 1'b1;
                else begin
                    for (int k = 1; k <= HOLD; k++) begin
                        exp_q[c+k].al = one << l;
                        exp_q[c+k].ar = one << r;
                        exp_q[c+k].ov = 1'b1;
                        exp_q[c+k].rdy = 1'b0;
                    end
                    exp_q[c+HOLD+1].done = 1'b1;
                end
            end
            default: begin
                if (d >= NR) exp_q[c+1].err = 1'b1;
                else begin
                    for (int k = 1; k <= 3; k++) begin
                        exp_q[c+k].ext = 1'b1;
                        exp_q[c+k].rdy = 1'b0;
                    end
                    exp_q[c+2].lt = one << d;
                    exp_q[c+4].done = 1'b1;
                    mregs[d[1:0]] = ext_bus;
                end
            end
        endcase
    endtask

    // Offer a command at the first ready negedge; fields are scrambled right after acceptance.
    task automatic send(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                        input logic [2:0] l, input logic [2:0] r, output int c);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_cmd_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk("send_ready", 32'(o_cmd_ready), 32'd1);
        i_cmd_valid = 1'b1; i_cmd_op = op;
        i_src = s; i_dst = d; i_left_sel = l; i_right_sel = r;
        c = cyc;
        model(c, op, s, d, l, r);
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        i_src       = 3'($urandom_range(7, 0));
        i_dst       = 3'($urandom_range(7, 0));
        i_left_sel  = 3'($urandom_range(7, 0));
        i_right_sel = 3'($urandom_range(7, 0));
        i_cmd_op    = 2'($urandom_range(3, 0));
    endtask

    task automatic at_cycle(input int t);
        @(negedge i_clk);
        while (cyc < t) @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c1, c2;
        checks = 0; errors = 0; chk_en = 1'b0; prev_lt = '0;
        regs[0] = 8'h11; regs[1] = 8'hA5; regs[2] = 8'h5A; regs[3] = 8'h00;
        for (int k = 0; k < NR; k++) mregs[k] = regs[k];
        ext_bus = 8'h3C;
        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_op = 2'd0;
        i_src = '0; i_dst = '0; i_left_sel = '0; i_right_sel = '0;
        fork
            begin
                // Register file latching on falling load strobes, and per-cycle compare.
                forever begin
                    @(negedge i_clk);
                    for (int k = 0; k < NR; k++) begin
                        if (prev_lt[k] && !o_load_transfer[k]) regs[k] = bus_val();
                    end
                    prev_lt = o_load_transfer;
                    if (chk_en) begin
                        checks++;
                        if (cur() !== exp_q[cyc]) begin
                            errors++;
                            $display("FAIL cycle_outputs at cycle %0d: got %h required %h", cyc, cur(), exp_q[cyc]);
                        end
                        checks++;
                        if ($countones(o_assert_transfer) > 1 || (o_ext_assert && o_assert_transfer != '0)) begin
                            errors++;
                            $display("FAIL bus_exclusive at cycle %0d: got at=%b ext=%b required one driver", cyc, o_assert_transfer, o_ext_assert);
                        end
                    end
                end
            end
            begin
                repeat (3) @(negedge i_clk);
                chk("reset_outputs", 32'(cur()), 32'd0);
                i_rst_n = 1'b1;
                #1 chk("ready_before_edge", 32'(o_cmd_ready), 32'd0);
                @(posedge i_clk);
                #1 chk("ready_after_edge", 32'(o_cmd_ready), 32'd1);
                reset_exp();
                chk_en = 1'b1;

                // MOVE 1 -> 3
                send(2'd1, 3'd1, 3'd3, 3'd0, 3'd0, c);
                at_cycle(c + 1); chk("move_c1_at", 32'(o_assert_transfer), 32'b0010);
                at_cycle(c + 2); chk("move_c2_lt", 32'(o_load_transfer), 32'b1000);
                chk("move_c2_at", 32'(o_assert_transfer), 32'b0010);
                at_cycle(c + 3); chk("move_c3_at", 32'(o_assert_transfer), 32'b0010);
                chk("move_c3_lt", 32'(o_load_transfer), 32'b0000);
                at_cycle(c + 4); chk("move_c4_done", 32'(o_done), 32'd1);
                chk("move_r3", 32'(regs[3]), 32'hA5);

                // ALU_READ left 0, right 2
                send(2'd2, 3'd0, 3'd0, 3'd0, 3'd2, c);
                at_cycle(c + 1); chk("alu_c1_left", 32'(o_assert_left), 32'b0001);
                chk("alu_c1_right", 32'(o_assert_right), 32'b0100);
                at_cycle(c + 3); chk("alu_c3_valid", 32'(o_operands_valid), 32'd1);
                at_cycle(c + 4); chk("alu_c4_done", 32'(o_done), 32'd1);
                chk("alu_c4_valid", 32'(o_operands_valid), 32'd0);

                // MOVE 2 -> 2 and out-of-range destination
                send(2'd1, 3'd2, 3'd2, 3'd0, 3'd0, c);
                at_cycle(c + 1); chk("same_done", 32'(o_done), 32'd1);
                chk("same_at", 32'(o_assert_transfer), 32'd0);
                send(2'd1, 3'd0, 3'd5, 3'd0, 3'd0, c);
                at_cycle(c + 1); chk("range_err", 32'(o_error), 32'd1);
                chk("range_done", 32'(o_done), 32'd0);

                // Model-only patterns, including back-to-back single-cycle commands
                send(2'd2, 3'd0, 3'd0, 3'd1, 3'd1, c);
                send(2'd3, 3'd0, 3'd4, 3'd0, 3'd0, c);
                send(2'd2, 3'd0, 3'd0, 3'd6, 3'd1, c);
                send(2'd0, 3'd0, 3'd0, 3'd0, 3'd0, c);
                send(2'd0, 3'd3, 3'd1, 3'd2, 3'd0, c);
                send(2'd1, 3'd2, 3'd0, 3'd0, 3'd0, c);
                send(2'd1, 3'd0, 3'd3, 3'd0, 3'd0, c);

                // LOAD_EXT into R0, then MOVE 0 -> 1 taken in the done cycle
                send(2'd3, 3'd2, 3'd0, 3'd0, 3'd0, c1);
                send(2'd1, 3'd0, 3'd1, 3'd0, 3'd0, c2);
                chk("b2b_accept_cycle", 32'(c2 - c1), 32'd4);
                at_cycle(c2 + 4);
                chk("b2b_r0", 32'(regs[0]), 32'h3C);
                chk("b2b_r1", 32'(regs[1]), 32'h3C);

                // Reset asserted during LATCH of MOVE 3 -> 0
                send(2'd1, 3'd3, 3'd0, 3'd0, 3'd0, c);
                at_cycle(c + 2); chk("irq_latch_lt", 32'(o_load_transfer), 32'b0001);
                #1;
                chk_en = 1'b0;
                i_rst_n = 1'b0;
                #1 chk("irq_async_clear", 32'(cur()), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge i_clk);
                    chk("irq_hold_quiet", 32'(cur()), 32'd0);
                end
                i_rst_n = 1'b1;
                #1 chk("irq_ready_before_edge", 32'(o_cmd_ready), 32'd0);
                @(posedge i_clk);
                #1 chk("irq_ready_after_edge", 32'(o_cmd_ready), 32'd1);
                // Destination contents are undefined after an interrupted latch.
                mregs[0] = regs[0];
                reset_exp();
                chk_en = 1'b1;

                send(2'd1, 3'd1, 3'd2, 3'd0, 3'd0, c);
                at_cycle(c + 5);
                for (int k = 0; k < NR; k++) chk("final_regs", 32'(regs[k]), 32'(mregs[k]));
                chk_en = 1'b0;
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
